// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receive path.
package gray_pkg;

  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  typedef enum logic [1:0] {HOLD, UP, DOWN, BAD} step_t;

  // Zero-extended Gray input decodes to the zero-extended binary value,
  // so callers of any WIDTH <= GRAY_MAX_W can cast in and truncate out.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_classify.sv
// Decodes a Gray sample and classifies its step against the previous binary value.
module gray_step_classify
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_in,
  input  logic [WIDTH-1:0] prev_bin,
  output logic [WIDTH-1:0] bin_c,
  output step_t            step_c
);

  logic [WIDTH-1:0] diff;

  // Modular difference: +1 and -1 both wrap naturally at 2^WIDTH.
  always_comb begin
    bin_c = WIDTH'(gray2bin(GRAY_MAX_W'(gray_in)));
    diff  = bin_c - prev_bin;
    if (diff == '0) begin
      step_c = HOLD;
    end else if (diff == WIDTH'(1)) begin
      step_c = UP;
    end else if (diff == '1) begin
      step_c = DOWN;
    end else begin
      step_c = BAD;
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// Gray-to-binary receiver with step legality checking, lock tracking and error count.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LOCK_N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     gray_in,
  output logic                 valid_out,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 dir,
  output logic                 step_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);

  state_t               state, state_d;
  logic [GOOD_W-1:0]    good_cnt, good_d;
  logic [ERR_CNT_W-1:0] err_d;
  logic [WIDTH-1:0]     bin_d;
  logic                 dir_d, valid_d, step_err_d;
  logic [WIDTH-1:0]     bin_c;
  step_t                step_c;

  // bin_out doubles as the previous accepted sample.
  gray_step_classify #(.WIDTH(WIDTH)) u_classify (
    .gray_in  (gray_in),
    .prev_bin (bin_out),
    .bin_c    (bin_c),
    .step_c   (step_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      good_cnt  <= '0;
      err_cnt   <= '0;
      bin_out   <= '0;
      dir       <= 1'b1;
      valid_out <= 1'b0;
      step_err  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      good_cnt  <= good_d;
      err_cnt   <= err_d;
      bin_out   <= bin_d;
      dir       <= dir_d;
      valid_out <= valid_d;
      step_err  <= step_err_d;
      locked    <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d    = state;
    good_d     = good_cnt;
    err_d      = err_cnt;
    bin_d      = bin_out;
    dir_d      = dir;
    valid_d    = 1'b0;
    step_err_d = 1'b0;

    if (clr) begin
      state_d = IDLE;
      good_d  = '0;
      err_d   = '0;
    end else if (valid_in) begin
      valid_d = 1'b1;
      bin_d   = bin_c;
      case (state)
        IDLE: begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
        ACQUIRE, LOCKED: begin
          case (step_c)
            UP, DOWN: begin
              dir_d = (step_c == UP);
              if (state == ACQUIRE) begin
                good_d = good_cnt + GOOD_W'(1);
                if (good_d >= GOOD_W'(LOCK_N)) begin
                  state_d = LOCKED;
                end
              end
            end
            BAD: begin
              step_err_d = 1'b1;
              good_d     = '0;
              state_d    = ACQUIRE;
              if (err_cnt != '1) begin
                err_d = err_cnt + ERR_CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// Directed bench for gray_decoder with an integer-arithmetic reference model.
module tb_gray_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       valid_in = 1'b0;
  logic [3:0] gray_in = 4'd0;
  logic       valid_out, dir, step_err, locked;
  logic [3:0] bin_out;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  gray_decoder #(.WIDTH(4), .LOCK_N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .valid_in  (valid_in),
    .gray_in   (gray_in),
    .valid_out (valid_out),
    .bin_out   (bin_out),
    .dir       (dir),
    .step_err  (step_err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference: decode by searching for n whose Gray code matches.
  function automatic int dec(input int g);
    for (int n = 0; n < 16; n++) begin
      if ((n ^ (n >> 1)) == g) return n;
    end
    return -1;
  endfunction

  logic m_valid = 1'b0;
  int   m_bin   = 0;
  logic m_dir   = 1'b1;
  logic m_serr  = 1'b0;
  int   m_err   = 0;
  int   m_mode  = 0;   // 0 idle, 1 acquiring, 2 locked
  int   m_good  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_bin <= 0; m_dir <= 1'b1; m_serr <= 1'b0;
      m_err <= 0; m_mode <= 0; m_good <= 0;
    end else if (clr) begin
      m_valid <= 1'b0; m_serr <= 1'b0; m_err <= 0; m_mode <= 0; m_good <= 0;
    end else if (!valid_in) begin
      m_valid <= 1'b0; m_serr <= 1'b0;
    end else begin : accept
      int nb;
      int d;
      nb = dec(int'(gray_in));
      d  = (nb - m_bin + 16) % 16;
      m_valid <= 1'b1;
      m_bin   <= nb;
      m_serr  <= 1'b0;
      if (m_mode == 0) begin
        m_mode <= 1; m_good <= 0;
      end else if (d == 1 || d == 15) begin
        m_dir <= (d == 1);
        if (m_mode == 1) begin
          m_good <= m_good + 1;
          if (m_good + 1 >= 3) m_mode <= 2;
        end
      end else if (d != 0) begin
        m_serr <= 1'b1;
        m_err  <= (m_err < 255) ? m_err + 1 : 255;
        m_good <= 0;
        m_mode <= 1;
      end
    end
  end

  task automatic model_cmp();
    checks++;
    if (valid_out !== m_valid || int'(bin_out) != m_bin || dir !== m_dir ||
        step_err !== m_serr || locked !== (m_mode == 2) || int'(err_cnt) != m_err) begin
      errors++;
      $display("FAIL model_cmp t=%0t got v=%0b b=%0d d=%0b e=%0b l=%0b c=%0d want v=%0b b=%0d d=%0b e=%0b l=%0b c=%0d",
               $time, valid_out, bin_out, dir, step_err, locked, err_cnt,
               m_valid, m_bin, m_dir, m_serr, (m_mode == 2), m_err);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_cmp();
  endtask

  task automatic send(input logic v, input logic [3:0] g, input logic c);
    valid_in = v;
    gray_in  = g;
    clr      = c;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bin"}, int'(bin_out), 0);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_dir"}, int'(dir), 1);
    chk({tag, "_serr"}, int'(step_err), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    chk("model_dec_0100", dec(4), 7);
    chk("model_dec_1000", dec(8), 15);
    rst = 1'b1;

    // Acquire and lock on 0,1,2,3
    send(1, 4'b0000, 0); chk("acq0_bin", int'(bin_out), 0); chk("acq0_valid", int'(valid_out), 1);
    chk("acq0_serr", int'(step_err), 0);
    send(1, 4'b0001, 0); chk("acq1_bin", int'(bin_out), 1);
    send(1, 4'b0011, 0); chk("acq2_bin", int'(bin_out), 2); chk("acq2_locked", int'(locked), 0);
    send(1, 4'b0010, 0); chk("acq3_bin", int'(bin_out), 3); chk("acq3_locked", int'(locked), 1);
    chk("acq3_dir", int'(dir), 1); chk("acq3_err", int'(err_cnt), 0);

    // Count up through the wrap
    for (int n = 4; n <= 17; n++) send(1, 4'((n % 16) ^ ((n % 16) >> 1)), 0);
    chk("upwrap_bin", int'(bin_out), 1); chk("upwrap_dir", int'(dir), 1);
    chk("upwrap_err", int'(err_cnt), 0); chk("upwrap_locked", int'(locked), 1);

    // Down through the wrap
    send(1, 4'b0011, 0);
    send(1, 4'b0001, 0); chk("dn_bin1", int'(bin_out), 1); chk("dn_dir", int'(dir), 0);
    send(1, 4'b0000, 0);
    send(1, 4'b1000, 0); chk("dnwrap_bin", int'(bin_out), 15); chk("dnwrap_locked", int'(locked), 1);

    // BAD step at 0 -> 7, then relock going down
    send(1, 4'b0000, 0); chk("pre_bad_bin", int'(bin_out), 0);
    send(1, 4'b0100, 0); chk("bad_bin", int'(bin_out), 7); chk("bad_serr", int'(step_err), 1);
    chk("bad_err", int'(err_cnt), 1); chk("bad_locked", int'(locked), 0);
    send(1, 4'b0101, 0); chk("re6_bin", int'(bin_out), 6); chk("re6_serr", int'(step_err), 0);
    send(1, 4'b0111, 0); chk("re5_locked", int'(locked), 0);
    send(1, 4'b0110, 0); chk("re4_bin", int'(bin_out), 4); chk("re4_dir", int'(dir), 0);
    chk("re4_locked", int'(locked), 1);

    // Gaps and holds
    repeat (3) send(0, 4'b0000, 0);
    chk("gap_valid", int'(valid_out), 0); chk("gap_bin", int'(bin_out), 4);
    send(1, 4'b0010, 0);
    send(1, 4'b0010, 0); chk("hold_valid", int'(valid_out), 1); chk("hold_bin", int'(bin_out), 3);
    chk("hold_serr", int'(step_err), 0); chk("hold_locked", int'(locked), 1);

    // Saturate the error counter
    for (int i = 0; i < 300; i++) send(1, (i % 2 == 0) ? 4'b0100 : 4'b0000, 0);
    chk("sat_err", int'(err_cnt), 255); chk("sat_locked", int'(locked), 0);

    // Asynchronous reset mid-stream
    send(1, 4'b0001, 0);
    send(1, 4'b0011, 0);
    valid_in = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset_vals("async");
    model_cmp();
    repeat (2) tick();
    rst = 1'b1;
    send(1, 4'b0110, 0); chk("post_rst_bin", int'(bin_out), 4); chk("post_rst_serr", int'(step_err), 0);
    chk("post_rst_valid", int'(valid_out), 1);
    send(1, 4'b0111, 0);

    // clr beats valid_in
    send(1, 4'b0000, 0); chk("pre_clr_err", int'(err_cnt), 1);
    send(1, 4'b0101, 1); chk("clr_valid", int'(valid_out), 0); chk("clr_err", int'(err_cnt), 0);
    chk("clr_bin", int'(bin_out), 0); chk("clr_locked", int'(locked), 0);
    send(1, 4'b1111, 0); chk("cap_bin", int'(bin_out), 10); chk("cap_serr", int'(step_err), 0);

    // HOLD in acquire does not count toward lock
    send(1, 4'b1111, 0);
    send(1, 4'b1110, 0);
    send(1, 4'b1010, 0); chk("acqhold_locked", int'(locked), 0);
    send(1, 4'b1011, 0); chk("acqhold_lock", int'(locked), 1);

    // BAD during acquire restarts the good count
    send(1, 4'b0000, 0);
    send(1, 4'b0001, 0);
    send(1, 4'b0011, 0);
    send(1, 4'b1000, 0); chk("acqbad_serr", int'(step_err), 1); chk("acqbad_err", int'(err_cnt), 2);
    send(1, 4'b0000, 0);
    send(1, 4'b0001, 0); chk("acqbad_nolock", int'(locked), 0);
    send(1, 4'b0011, 0); chk("acqbad_lock", int'(locked), 1);
    send(0, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
